// File: rtl/arbitro_memoria_if.sv
// rtl/arbitro_memoria_if.sv - request/ack ports and memory bus of the instruction/data memory arbiter
interface arbitro_memoria_if #(
    parameter int BUS = 31
);
    logic           inst_req;
    logic [BUS:0]   inst_addr;
    logic           inst_ack;
    logic           inst_err;
    logic [BUS:0]   inst_rdata;
    logic           data_req;
    logic [BUS:0]   data_addr;
    logic           data_ack;
    logic [BUS:0]   data_rdata;
    logic           mem_enable;
    logic           mem_readmem;
    logic [BUS:0]   mem_dir_instru;
    logic [BUS:0]   mem_dir_mem;
    logic [BUS:0]   mem_dato_instru;
    logic [BUS:0]   mem_dato_mem;

    // arbiter side
    modport slave (
        input  inst_req, inst_addr, data_req, data_addr, mem_dato_instru, mem_dato_mem,
        output inst_ack, inst_err, inst_rdata, data_ack, data_rdata,
               mem_enable, mem_readmem, mem_dir_instru, mem_dir_mem
    );

    // requesters plus memory
    modport master (
        output inst_req, inst_addr, data_req, data_addr, mem_dato_instru, mem_dato_mem,
        input  inst_ack, inst_err, inst_rdata, data_ack, data_rdata,
               mem_enable, mem_readmem, mem_dir_instru, mem_dir_mem
    );
endinterface

// File: rtl/arbitro_memoria.sv
// rtl/arbitro_memoria.sv - arbiter sharing one registered memory between instruction fetch and data read ports
module arbitro_memoria #(
    parameter int BUS       = 31,
    parameter int DATA_PRIO = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    arbitro_memoria_if.slave    bus
);
    typedef enum logic [2:0] {IDLE, ACC_I, ACC_D, CAP_I, CAP_D, ERR_I} state_t;

    state_t         state, state_n;
    logic           last_grant, last_grant_n;   // 1 = data port was granted last
    logic           mem_enable_q, mem_enable_n;
    logic           mem_readmem_q, mem_readmem_n;
    logic [BUS:0]   dir_instru_q, dir_instru_n;
    logic [BUS:0]   dir_mem_q, dir_mem_n;
    logic           inst_ack_q, inst_ack_n;
    logic           inst_err_q, inst_err_n;
    logic [BUS:0]   inst_rdata_q, inst_rdata_n;
    logic           data_ack_q, data_ack_n;
    logic [BUS:0]   data_rdata_q, data_rdata_n;
    logic           grant_inst, grant_data;

    // On a conflict the instruction port wins only under round-robin when data went last
    assign grant_inst = bus.inst_req &&
                        (!bus.data_req || ((DATA_PRIO == 0) && last_grant));
    assign grant_data = bus.data_req && !grant_inst;

    always_comb begin
        state_n       = state;
        last_grant_n  = last_grant;
        mem_enable_n  = 1'b1;
        mem_readmem_n = 1'b1;
        dir_instru_n  = dir_instru_q;
        dir_mem_n     = dir_mem_q;
        inst_ack_n    = 1'b0;
        inst_err_n    = 1'b0;
        inst_rdata_n  = inst_rdata_q;
        data_ack_n    = 1'b0;
        data_rdata_n  = data_rdata_q;
        case (state)
            IDLE: begin
                if (grant_inst) begin
                    last_grant_n = 1'b0;
                    if (bus.inst_addr[1:0] != 2'b00) begin
                        state_n = ERR_I;
                    end else begin
                        dir_instru_n = bus.inst_addr;
                        mem_enable_n = 1'b0;
                        state_n      = ACC_I;
                    end
                end else if (grant_data) begin
                    last_grant_n  = 1'b1;
                    dir_mem_n     = bus.data_addr;
                    mem_readmem_n = 1'b0;
                    state_n       = ACC_D;
                end
            end
            ACC_I: state_n = CAP_I;
            ACC_D: state_n = CAP_D;
            CAP_I: begin
                inst_rdata_n = bus.mem_dato_instru;
                inst_ack_n   = 1'b1;
                state_n      = IDLE;
            end
            CAP_D: begin
                data_rdata_n = bus.mem_dato_mem;
                data_ack_n   = 1'b1;
                state_n      = IDLE;
            end
            ERR_I: begin
                inst_rdata_n = '0;
                inst_err_n   = 1'b1;
                inst_ack_n   = 1'b1;
                state_n      = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            mem_enable_q  <= 1'b1;
            mem_readmem_q <= 1'b1;
            dir_instru_q  <= '0;
            dir_mem_q     <= '0;
            inst_ack_q    <= 1'b0;
            inst_err_q    <= 1'b0;
            inst_rdata_q  <= '0;
            data_ack_q    <= 1'b0;
            data_rdata_q  <= '0;
        end else begin
            state         <= state_n;
            last_grant    <= last_grant_n;
            mem_enable_q  <= mem_enable_n;
            mem_readmem_q <= mem_readmem_n;
            dir_instru_q  <= dir_instru_n;
            dir_mem_q     <= dir_mem_n;
            inst_ack_q    <= inst_ack_n;
            inst_err_q    <= inst_err_n;
            inst_rdata_q  <= inst_rdata_n;
            data_ack_q    <= data_ack_n;
            data_rdata_q  <= data_rdata_n;
        end
    end

    assign bus.mem_enable     = mem_enable_q;
    assign bus.mem_readmem    = mem_readmem_q;
    assign bus.mem_dir_instru = dir_instru_q;
    assign bus.mem_dir_mem    = dir_mem_q;
    assign bus.inst_ack       = inst_ack_q;
    assign bus.inst_err       = inst_err_q;
    assign bus.inst_rdata     = inst_rdata_q;
    assign bus.data_ack       = data_ack_q;
    assign bus.data_rdata     = data_rdata_q;
endmodule

// File: doc/arbitro_memoria.md
ARBITRO_MEMORIA -- requirements
Module: arbitro_memoria

Interface
REQ-001 SHALL have parameter: BUS, 31, MSB index of all address/data buses (width BUS+1).
REQ-002 SHALL have parameter: DATA_PRIO, 0, 1 = data port always wins a conflict; 0 = round-robin.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: inst_req  input  1  instruction fetch request, held until inst_ack.
REQ-006 SHALL have port: inst_addr  input  BUS+1  fetch address (PC).
REQ-007 SHALL have port: inst_ack  output  1  one-cycle pulse: inst_rdata/inst_err valid.
REQ-008 SHALL have port: inst_err  output  1  fetch rejected (misaligned); valid with inst_ack.
REQ-009 SHALL have port: inst_rdata  output  BUS+1  fetched instruction word.
REQ-010 SHALL have port: data_req  input  1  data read request, held until data_ack.
REQ-011 SHALL have port: data_addr  input  BUS+1  data address.
REQ-012 SHALL have port: data_ack  output  1  one-cycle pulse: data_rdata valid.
REQ-013 SHALL have port: data_rdata  output  BUS+1  data word read.
REQ-014 SHALL have port: mem_enable  output  1  memory enable flag (0 = instruction access).
REQ-015 SHALL have port: mem_readmem  output  1  memory read flag (0 = data access).
REQ-016 SHALL have port: mem_dir_instru  output  BUS+1  memory instruction address.
REQ-017 SHALL have port: mem_dir_mem  output  BUS+1  memory data address.
REQ-018 SHALL have port: mem_dato_instru  input  BUS+1  memory instruction output (registered, 1-cycle).
REQ-019 SHALL have port: mem_dato_mem  input  BUS+1  memory data output (registered, 1-cycle).

Function
REQ-020 SHALL implement FSM states IDLE, ACC_I, ACC_D, CAP_I, CAP_D, ERR_I; all outputs registered.
REQ-021 IDLE SHALL drive mem_enable=1, mem_readmem=1 (no access); addresses hold last value.
REQ-022 IDLE, inst_req only, inst_addr[1:0]=0: latch addr to mem_dir_instru, drive mem_enable=0/mem_readmem=1, go ACC_I.
REQ-023 IDLE, data_req only: latch addr to mem_dir_mem, drive mem_enable=1/mem_readmem=0, go ACC_D.
REQ-024 IDLE, inst_req with inst_addr[1:0]≠0 and instruction granted: no memory access, go ERR_I.
REQ-025 Both requests in IDLE: DATA_PRIO=1 grants data; DATA_PRIO=0 grants the port not in last_grant.
REQ-026 last_grant SHALL update on every grant (including ERR_I as instruction).
REQ-027 ACC_x SHALL hold memory controls one cycle (memory samples), then go CAP_x with controls back to idle (1/1).
REQ-028 CAP_I: register mem_dato_instru into inst_rdata, pulse inst_ack, go IDLE; CAP_D likewise for data.
REQ-029 ERR_I: inst_rdata=0, inst_err=1 with inst_ack pulse, go IDLE.
REQ-030 Latency: req sampled at edge E0 -> ack high in the cycle after edge E2 (3 cycles); ERR path 2 cycles.
REQ-031 ack and err SHALL be high exactly one cycle; rdata SHALL hold until next ack on that port.
REQ-032 Requests arriving while not IDLE SHALL wait; grant only from IDLE; no request dropped.
REQ-033 Requester deasserting req mid-access SHALL not abort; access completes and ack pulses.
REQ-034 Never SHALL mem_enable=0 and mem_readmem=0 simultaneously.

Reset
REQ-035 rst_n low SHALL immediately force: state IDLE, mem_enable=1, mem_readmem=1, mem_dir_instru=0, mem_dir_mem=0, inst_ack=0, inst_err=0, data_ack=0, inst_rdata=0, data_rdata=0, last_grant=data.
REQ-036 Reset during ACC/CAP SHALL abort the access with no ack; first access after release follows REQ-022..025.

Verification
REQ-037 inst_req, inst_addr=0x00400004 -> mem_enable=0 one cycle, inst_rdata=0x01000110, inst_ack 3 cycles after request edge.
REQ-038 data_req, data_addr=0x10000000 -> mem_readmem=0 one cycle, data_rdata=0x00000100, data_ack after 3 cycles.
REQ-039 DATA_PRIO=0, both req from reset -> instruction served first, data acked 3 cycles later; repeat -> order alternates.
REQ-040 DATA_PRIO=1, both req -> data acked first, then instruction.
REQ-041 inst_addr=0x00400002 -> no memory access, inst_ack+inst_err after 2 cycles, inst_rdata=0.
REQ-042 rst_n pulsed low in ACC_I -> all outputs at reset values asynchronously, no inst_ack; re-request at 0x00400000 -> inst_rdata=0x00000010.
